// File: rtl/display_scan_mux.sv
// Four-digit seven-segment scan multiplexer with frame-aligned snapshot, blink and anti-ghost dead time.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank a leading zero in the hours-tens position.
module display_scan_mux #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 4000,
  parameter int BLINK_HZ    = 2,
  parameter int DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] hours_tens,
  input  logic [3:0] hours_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] blink_mask,
  input  logic       colon_on,
  output logic [3:0] digit,
  output logic [3:0] anode_n,
  output logic       dp_n,
  output logic       frame_start
);

  localparam int TICK_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = SCAN_HZ / (2 * BLINK_HZ);
  localparam int CW        = $clog2(TICK_DIV + 1);
  localparam int BW        = $clog2(BLINK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

  logic [CW-1:0]     cnt, cnt_nxt;
  logic              tick;
  logic [1:0]        pos, pos_nxt;
  logic [BW-1:0]     bcnt, bcnt_nxt;
  logic              phase, phase_nxt;
  logic [3:0][3:0]   snap, snap_nxt;
  logic              primed, primed_nxt;
  logic              frame_nxt;
  logic [3:0]        digit_nxt, anode_nxt, sel;
  logic              dp_nxt, dead, blank, lz;

  // Scan timing and frame snapshot.
  always_comb begin
    tick       = (cnt == CNT_MAX);
    cnt_nxt    = tick ? '0 : cnt + CW'(1);
    pos_nxt    = tick ? pos + 2'd1 : pos;
    bcnt_nxt   = bcnt;
    phase_nxt  = phase;
    if (tick) begin
      if (bcnt == BCNT_MAX) begin
        bcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        bcnt_nxt  = bcnt + BW'(1);
      end
    end
    frame_nxt  = tick && (pos == 2'd3);
    snap_nxt   = frame_nxt ? {hours_tens, hours_ones, min_tens, min_ones} : snap;
    primed_nxt = primed | frame_nxt;
  end

  // Outputs are decoded from next-state values so they land one cycle after the tick.
  always_comb begin
    sel   = snap_nxt[pos_nxt];
    dead  = (cnt_nxt < DEAD_LIM);
    blank = !phase_nxt && blink_mask[pos_nxt];
`ifdef LEADING_ZERO_BLANK_EN
    lz    = (pos_nxt == 2'd3) && (snap_nxt[3] == 4'h0);
`else
    lz    = 1'b0;
`endif
    digit_nxt = (blank || lz) ? 4'hF : sel;
    anode_nxt = 4'hF;
    // Nothing is lit until the first real snapshot has been taken.
    if (!(dead || blank || lz || !primed_nxt)) anode_nxt[pos_nxt] = 1'b0;
    dp_nxt = !((pos_nxt == 2'd2) && colon_on && !dead && !blank);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      pos         <= 2'd0;
      bcnt        <= '0;
      phase       <= 1'b1;
      snap        <= {4{4'hF}};
      primed      <= 1'b0;
      digit       <= 4'hF;
      anode_n     <= 4'hF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      pos         <= pos_nxt;
      bcnt        <= bcnt_nxt;
      phase       <= phase_nxt;
      snap        <= snap_nxt;
      primed      <= primed_nxt;
      digit       <= digit_nxt;
      anode_n     <= anode_nxt;
      dp_n        <= dp_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexed scan controller for the alarm clock's 4-digit common-anode seven-segment display. It sits directly upstream of the seven-segment decoder. Each cycle it selects one BCD digit of the HH:MM value and presents it on `digit` for the decoder. It drives the active-low anodes and the colon/decimal point, and applies per-digit blinking for time/alarm set mode. Snapshots are frame-aligned so a digit update never tears mid-frame.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SCAN_HZ`, 4000, digit-step rate; one full frame = 4 steps.
- `BLINK_HZ`, 2, blink frequency; one on phase + one off phase per period.
- `DEAD_CYCLES`, 8, cycles all anodes are held off after each digit step (anti-ghosting); must be < `CLK_HZ/SCAN_HZ`.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `hours_tens`, `hours_ones`, `min_tens`, `min_ones` in 4 each: BCD digits.
- `blink_mask` in 4: bit i set → position i blinks (0 = `min_ones`, 3 = `hours_tens`).
- `colon_on` in 1: light DP on position 2.
- `digit` out 4: nibble to the decoder; 4'hF = blank (decoder default).
- `anode_n` out 4: active-low digit enables.
- `dp_n` out 1: active-low decimal point.
- `frame_start` out 1: one-cycle pulse when position 0 is entered.

## Operation
- **Prescaler.** Counts 0..`TICK_DIV-1`, where `TICK_DIV = CLK_HZ/SCAN_HZ` (integer division). `tick` is asserted in the cycle the count equals `TICK_DIV-1`; the count then wraps to 0.
- **Scan index.** 2-bit `pos`, sequence 0→1→2→3→0, advancing on `tick`.
- **Snapshot.** On the `tick` that wraps 3→0, all four input digits are registered. All displayed values come from the snapshot, never the live inputs. `frame_start` pulses in that same cycle.
- **Digit select.** pos0 = `min_ones`, pos1 = `min_tens`, pos2 = `hours_ones`, pos3 = `hours_tens`. Values above 9 pass through unchanged; the decoder blanks them.
- **Blink.** A tick counter toggles `blink_phase` every `SCAN_HZ/(2*BLINK_HZ)` ticks. `blink_phase` resets to 1 (visible). While `blink_phase`=0 and `blink_mask[pos]`=1:
  - `anode_n[pos]` stays 1;
  - `digit` = 4'hF.
- **`blink_mask`.** Sampled live every cycle, so clearing it restores the digit immediately. It does not reset `blink_phase`.
- **Dead time.**
  - For the first `DEAD_CYCLES` cycles after each `tick`, `anode_n` = 4'b1111 and `dp_n` = 1.
  - During dead time `digit` already shows the new position.
  - After dead time, `anode_n` = one-hot-low at `pos`.
- **DP.** `dp_n` = 0 only when: `pos`=2, `colon_on`=1, outside dead time, and the digit is not blink-blanked.

## Timing
- **Reset (async assert):**
  - `anode_n` = 4'b1111, `digit` = 4'hF, `dp_n` = 1, `frame_start` = 0.
  - Internal: `pos` = 0, prescaler = 0, `blink_phase` = 1, snapshot = 4'hF ×4.
- **First frame after reset:**
  - First `tick` occurs at cycle `TICK_DIV-1` after reset release.
  - `pos` stays 0 until then, with anodes off (snapshot is blank).
- **Output registration.** All outputs are registered. Position/anode changes appear one cycle after the `tick` cycle.
- **Reset mid-frame.** Outputs go blank immediately; the scan restarts at pos 0 with a fresh prescaler.
- **Input timing.** A digit change is visible from the next frame boundary. Latency is at most `4*TICK_DIV` + 1 cycles.

## Configuration
- **`LEADING_ZERO_BLANK_EN` defined:** if the snapshot `hours_tens` = 0, pos3 outputs `digit` = 4'hF and `anode_n[3]` stays 1 (e.g. "9:05" instead of "09:05").
- **`LEADING_ZERO_BLANK_EN` undefined:** zero is displayed normally. No other behaviour differs.

## Test plan
Parameters for all tests: `CLK_HZ`=100, `SCAN_HZ`=10 (`TICK_DIV`=10), `BLINK_HZ`=1 (toggle every 5 ticks), `DEAD_CYCLES`=2.
- **Reset:** assert `reset_n`=0 mid-scan → same cycle `anode_n`=1111, `digit`=F, `dp_n`=1; after release, first `tick` at cycle 9.
- **Scan:** inputs 1,2,3,4 (HH=12, MM=34) → after the first frame boundary, `digit` sequence 4,3,2,1. Anodes 1110,1101,1011,0111, each asserted 8 cycles after 2 dead cycles of 1111. `frame_start` every 40 cycles.
- **Tear-free update:** change `min_ones` 4→7 at mid-frame → `digit` at pos0 shows 4 until the next frame, then 7.
- **Blink:** `blink_mask`=0011 → pos0/pos1 anodes off and `digit`=F for 5 ticks, on for 5 ticks. pos2/pos3 are unaffected.
- **Colon:** `colon_on`=1 → `dp_n`=0 only during the 8 non-dead cycles of pos2; with `blink_mask[2]`=1 in the off phase, `dp_n`=1.
- **Leading zero:** `hours_tens`=0 with `LEADING_ZERO_BLANK_EN` → pos3 `anode_n`=1111, `digit`=F. Without the macro → `digit`=0, `anode_n`=0111.
